filter_scheduler: RTL and testbench

FILTER_SCHEDULER -- requirements
Module: filter_scheduler

---
 rtl/filter_sched_pkg.sv | 30 +++
 rtl/filter_scheduler_win_pos_counter.sv | 64 ++++++
 rtl/filter_scheduler.sv | 162 ++++++++++++++++
 tb/tb_filter_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sched_pkg.sv
// Shared definitions for the filter scheduler slice.
// Contents:
//   sched_state_t : scheduler FSM state encoding
//   N_FILT        : number of filters applied per window position
//   K_SIZE        : convolution kernel edge length
//   is_busy()     : decode of the states in which a pass is in progress
package filter_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } sched_state_t;

    localparam int N_FILT = 4;
    localparam int K_SIZE = 3;

    // A pass is in progress while fetching, issuing or advancing.
    function automatic logic is_busy(input sched_state_t s);
        logic b;
        case (s)
            FETCH, ISSUE, ADVANCE: b = 1'b1;
            default:               b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/filter_scheduler_win_pos_counter.sv
// Row-major window position counter for the filter scheduler.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   step  : advance to the next window position
//   clear : return to position (0,0)
//   row   : current window top row
//   col   : current window left column
//   last  : current position is the final one of the image
module win_pos_counter
    import filter_sched_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          clear,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          col_end_s;
    logic          row_end_s;

    assign col_end_s = (col_r == CW'(IMG_W - K_SIZE));
    assign row_end_s = (row_r == RW'(IMG_H - K_SIZE));
    assign last      = col_end_s && row_end_s;
    assign row       = row_r;
    assign col       = col_r;

    // Position register: column wraps into the next row; stepping past the
    // final position returns to (0,0) so the counter is clean for the next pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_r <= '0;
            col_r <= '0;
        end else if (clear) begin
            row_r <= '0;
            col_r <= '0;
        end else if (step) begin
            if (col_end_s) begin
                col_r <= '0;
                if (row_end_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1'b1);
                end
            end else begin
                col_r <= col_r + CW'(1'b1);
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

endmodule

// File: rtl/filter_scheduler.sv
// Filter scheduler: walks every 3x3 window position of an image in row-major
// order, fetches each window, then issues it to the convolution engine once
// per filter (0..3) with a valid/ready handshake.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start, abort       : begin a pass (IDLE only) / cancel the pass (any state)
//   busy, done         : pass in progress / one-cycle end-of-pass pulse
//   win_req/row/col    : window request and its top-left coordinate
//   win_valid          : requested window is present
//   filter_used        : filter-mux select, straight from the filter register
//   conv_valid/ready   : issue handshake to the conv engine
//   out_row/col/ch     : tags of the issue, valid with conv_valid
module filter_scheduler
    import filter_sched_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          win_req,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          win_valid,
    output logic [1:0]    filter_used,
    output logic          conv_valid,
    input  logic          conv_ready,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic [1:0]    out_ch
);

    sched_state_t  state_r;
    sched_state_t  state_nx_s;
    logic [1:0]    filter_r;
    logic [1:0]    filter_nx_s;
    logic          step_s;
    logic          clear_s;
    logic          last_s;
    logic [RW-1:0] row_s;
    logic [CW-1:0] col_s;
    logic          busy_r;
    logic          done_r;
    logic          win_req_r;
    logic          conv_valid_r;

    win_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RW    (RW),
        .CW    (CW)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step_s),
        .clear (clear_s),
        .row   (row_s),
        .col   (col_s),
        .last  (last_s)
    );

    // Next-state, filter and counter control; abort overrides every handshake.
    always_comb begin
        state_nx_s  = state_r;
        filter_nx_s = filter_r;
        step_s      = 1'b0;
        clear_s     = 1'b0;
        if (abort) begin
            state_nx_s  = IDLE;
            filter_nx_s = 2'd0;
            clear_s     = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nx_s  = FETCH;
                        filter_nx_s = 2'd0;
                        clear_s     = 1'b1;
                    end else begin
                        state_nx_s  = IDLE;
                    end
                end
                FETCH: begin
                    if (win_valid) begin
                        state_nx_s = ISSUE;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end
                ISSUE: begin
                    // conv_valid is high throughout ISSUE, so ready alone
                    // completes the handshake.
                    if (conv_ready) begin
                        if (filter_r == 2'(N_FILT - 1)) begin
                            filter_nx_s = 2'd0;
                            state_nx_s  = ADVANCE;
                        end else begin
                            filter_nx_s = filter_r + 2'd1;
                            state_nx_s  = ISSUE;
                        end
                    end else begin
                        state_nx_s = ISSUE;
                    end
                end
                ADVANCE: begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end
                DONE: begin
                    state_nx_s = IDLE;
                end
                default: begin
                    state_nx_s  = IDLE;
                    filter_nx_s = 2'd0;
                    clear_s     = 1'b1;
                end
            endcase
        end
    end

    // State, filter and control outputs, registered from the next state so
    // each output flop is aligned with the state it decodes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            filter_r     <= 2'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            win_req_r    <= 1'b0;
            conv_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            filter_r     <= filter_nx_s;
            busy_r       <= is_busy(state_nx_s);
            done_r       <= (state_nx_s == DONE);
            win_req_r    <= (state_nx_s == FETCH);
            conv_valid_r <= (state_nx_s == ISSUE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign win_req     = win_req_r;
    assign conv_valid  = conv_valid_r;
    assign win_row     = row_s;
    assign win_col     = col_s;
    assign out_row     = row_s;
    assign out_col     = col_s;
    assign filter_used = filter_r;
    assign out_ch      = filter_r;

endmodule

// File: tb/tb_filter_scheduler.sv
module tb_filter_scheduler;

    typedef struct {
        int r;
        int c;
        int ch;
    } tag_t;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, win_valid, conv_ready, start_b;
    logic       busy, done, win_req, conv_valid;
    logic [1:0] win_row, win_col, out_row, out_col, filter_used, out_ch;
    logic       busy_b, done_b, win_req_b, conv_valid_b;
    logic [1:0] win_row_b, win_col_b, out_row_b, out_col_b, filter_used_b, out_ch_b;

    int   total = 0;
    int   bad   = 0;
    tag_t exp_q[$];

    always #5 clk = ~clk;

    filter_scheduler #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .win_req(win_req), .win_row(win_row),
        .win_col(win_col), .win_valid(win_valid), .filter_used(filter_used),
        .conv_valid(conv_valid), .conv_ready(conv_ready),
        .out_row(out_row), .out_col(out_col), .out_ch(out_ch)
    );

    filter_scheduler #(.IMG_W(3), .IMG_H(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .busy(busy_b), .done(done_b), .win_req(win_req_b), .win_row(win_row_b),
        .win_col(win_col_b), .win_valid(win_valid), .filter_used(filter_used_b),
        .conv_valid(conv_valid_b), .conv_ready(conv_ready),
        .out_row(out_row_b), .out_col(out_col_b), .out_ch(out_ch_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference order: every window position row-major, filters 0..3 each.
    task automatic fill_queue();
        tag_t t;
        exp_q.delete();
        for (int r = 0; r < 4 - 2; r++)
            for (int c = 0; c < 4 - 2; c++)
                for (int f = 0; f < 4; f++) begin
                    t.r = r; t.c = c; t.ch = f;
                    exp_q.push_back(t);
                end
    endtask

    function automatic bit head_is(input int r, input int c, input int ch);
        if (exp_q.size() == 0) return 1'b0;
        return (exp_q[0].r == r) && (exp_q[0].c == c) && (exp_q[0].ch == ch);
    endfunction

    // Scoreboard step for one cycle of DUT A, sampled at the falling edge.
    task automatic observe(inout int hs);
        tag_t t;
        if (conv_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_issue", 32'd1, 32'd0);
            end else begin
                chk("out_row", 32'(out_row), exp_q[0].r);
                chk("out_col", 32'(out_col), exp_q[0].c);
                chk("out_ch", 32'(out_ch), exp_q[0].ch);
                chk("filter_used", 32'(filter_used), exp_q[0].ch);
                chk("winreq_in_issue", 32'(win_req), 32'd0);
                if (conv_ready && !abort && rst_n) begin
                    t = exp_q.pop_front();
                    hs++;
                end
            end
        end else if (win_req) begin
            if (exp_q.size() == 0) begin
                chk("extra_fetch", 32'd1, 32'd0);
            end else begin
                chk("win_row", 32'(win_row), exp_q[0].r);
                chk("win_col", 32'(win_col), exp_q[0].c);
            end
        end
        if (done) chk("done_early", exp_q.size(), 32'd0);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_winreq"}, 32'(win_req), 32'd0);
        chk({tag, "_cvalid"}, 32'(conv_valid), 32'd0);
        chk({tag, "_filt"}, 32'(filter_used), 32'd0);
        chk({tag, "_row"}, 32'(out_row), 32'd0);
        chk({tag, "_col"}, 32'(out_col), 32'd0);
    endtask

    // mode 0: free-flowing, 1: random stalls + stray starts, 2: backpressure
    // at (0,1,ch2), 3: window stall at (1,0), 4: abort at (1,0,ch1),
    // 5: reset at (0,1,ch3).
    task automatic run_pass(input int mode);
        int  stall, wstall, cyc, lat, hs, dn;
        bit  fin, evt;
        fill_queue();
        stall = 0; wstall = 0; hs = 0; dn = 0; lat = -1; fin = 0; evt = 0; cyc = 0;
        start = 1'b1; abort = 1'b0; win_valid = 1'b1; conv_ready = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;
        while (!fin && cyc < 600) begin
            start = 1'b0; abort = 1'b0; rst_n = 1'b1; conv_ready = 1'b1; win_valid = 1'b1;
            if (mode == 1) begin
                conv_ready = 1'($urandom_range(0, 1));
                win_valid  = 1'($urandom_range(0, 1));
                start      = (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
            end
            if (mode == 2 && head_is(0, 1, 2) && stall < 3) conv_ready = 1'b0;
            if (mode == 3 && head_is(1, 0, 0) && wstall < 5) win_valid = 1'b0;
            if (mode == 4 && head_is(1, 0, 1)) begin abort = 1'b1; evt = 1'b1; end
            if (mode == 5 && head_is(0, 1, 3)) begin rst_n = 1'b0; evt = 1'b1; end
            @(negedge clk);
            if (lat < 0 && conv_valid) lat = cyc + 1;
            if (mode == 2 && !conv_ready && stall < 3) begin
                chk("bp_cvalid", 32'(conv_valid), 32'd1);
                chk("bp_filt", 32'(filter_used), 32'd2);
                chk("bp_row", 32'(out_row), 32'd0);
                chk("bp_col", 32'(out_col), 32'd1);
                stall++;
            end
            if (mode == 3 && head_is(1, 0, 0) && (wstall > 0 || win_req) && wstall < 5) begin
                chk("ws_winreq", 32'(win_req), 32'd1);
                chk("ws_row", 32'(win_row), 32'd1);
                chk("ws_col", 32'(win_col), 32'd0);
                chk("ws_cvalid", 32'(conv_valid), 32'd0);
                wstall++;
            end
            observe(hs);
            if (done) begin
                dn++;
                chk("done_busy", 32'(busy), 32'd0);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (evt) begin
                rst_n = 1'b1; abort = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    idle_checks(mode == 4 ? "abort" : "midreset");
                    @(posedge clk); #1;
                end
                exp_q.delete();
                fin = 1'b1;
            end
        end
        chk("pass_finished", 32'(fin), 32'd1);
        if (mode <= 3) begin
            chk("handshakes", hs, 32'd16);
            chk("done_count", dn, 32'd1);
            chk("queue_empty", exp_q.size(), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        if (mode == 0) chk("latency_ge2", 32'(lat >= 2), 32'd1);
        if (mode == 2) chk("bp_stall_cycles", stall, 32'd3);
        if (mode == 3) chk("ws_stall_cycles", wstall, 32'd5);
    endtask

    initial begin
        int hs_b, dn_b;
        rst_n = 1'b0; start = 1'b1; start_b = 1'b1; abort = 1'b1;
        win_valid = 1'b1; conv_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_checks("reset");
            chk("reset_b_busy", 32'(busy_b), 32'd0);
            chk("reset_b_cvalid", 32'(conv_valid_b), 32'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; start = 1'b0; start_b = 1'b0; abort = 1'b0;
        @(posedge clk); #1;

        run_pass(0);
        run_pass(2);
        run_pass(3);
        run_pass(4);
        run_pass(0);
        run_pass(5);
        run_pass(0);
        for (int p = 0; p < 3; p++) run_pass(1);

        // Minimum 3x3 image: a single position, four issues, then done.
        conv_ready = 1'b1; win_valid = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; hs_b = 0; dn_b = 0;
        for (int i = 0; i < 40 && dn_b == 0; i++) begin
            @(negedge clk);
            if (win_req_b) begin
                chk("b_win_row", 32'(win_row_b), 32'd0);
                chk("b_win_col", 32'(win_col_b), 32'd0);
            end
            if (conv_valid_b) begin
                chk("b_row", 32'(out_row_b), 32'd0);
                chk("b_col", 32'(out_col_b), 32'd0);
                chk("b_ch", 32'(out_ch_b), hs_b);
                chk("b_filt", 32'(filter_used_b), hs_b);
                chk("b_busy", 32'(busy_b), 32'd1);
                hs_b++;
            end
            if (done_b) dn_b++;
            @(posedge clk); #1;
        end
        chk("b_handshakes", hs_b, 32'd4);
        chk("b_done", dn_b, 32'd1);
        @(negedge clk);
        chk("b_done_one_cycle", 32'(done_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
